// File: rtl/arb_pkg.sv
// Shared definitions for the sram-like bus: arbiter state codes, transfer sizes,
// and the grant priority rule.
package arb_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_I_ADDR = 3'd1;
    localparam logic [2:0] ST_I_DATA = 3'd2;
    localparam logic [2:0] ST_D_ADDR = 3'd3;
    localparam logic [2:0] ST_D_DATA = 3'd4;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Data port wins; fetch only gets the bus when no data request is waiting.
    function automatic logic [2:0] pick(input logic data_req, input logic inst_req);
        if (data_req)
            return ST_D_ADDR;
        else if (inst_req)
            return ST_I_ADDR;
        else
            return ST_IDLE;
    endfunction

endpackage

// File: rtl/sram_like_mux2.sv
// Grant-select mux for one sram-like request bundle; drives zeros when not enabled.
module sram_like_mux2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          en,
    input  logic          sel,
    input  logic          a_req,
    input  logic          a_wr,
    input  logic [1:0]    a_size,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    input  logic          b_req,
    input  logic          b_wr,
    input  logic [1:0]    b_size,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          y_req,
    output logic          y_wr,
    output logic [1:0]    y_size,
    output logic [AW-1:0] y_addr,
    output logic [DW-1:0] y_wdata
);

    always_comb begin
        y_req   = 1'b0;
        y_wr    = 1'b0;
        y_size  = 2'd0;
        y_addr  = '0;
        y_wdata = '0;
        if (en) begin
            if (sel) begin
                y_req   = b_req;
                y_wr    = b_wr;
                y_size  = b_size;
                y_addr  = b_addr;
                y_wdata = b_wdata;
            end else begin
                y_req   = a_req;
                y_wr    = a_wr;
                y_size  = a_size;
                y_addr  = a_addr;
                y_wdata = a_wdata;
            end
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Serialises the core's instruction and data sram-like ports onto one master port;
// one transaction outstanding, data port has priority.
module sram_like_arbiter
    import arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic          inst_wr,
    input  logic [1:0]    inst_size,
    input  logic [AW-1:0] inst_addr,
    input  logic [DW-1:0] inst_wdata,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,
    output logic          m_req,
    output logic          m_wr,
    output logic [1:0]    m_size,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_addr_ok,
    input  logic          m_data_ok,
    input  logic [DW-1:0] m_rdata
);

    logic [2:0] state_reg;
    logic [2:0] state_next;
    logic       addr_phase;
    logic       sel_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    assign addr_phase = (state_reg == ST_I_ADDR) || (state_reg == ST_D_ADDR);
    assign sel_data   = (state_reg == ST_D_ADDR);

    // The request bundle is never latched: requesters hold it stable until addr_ok.
    sram_like_mux2 #(.AW(AW), .DW(DW)) u_mux (
        .en      (addr_phase),
        .sel     (sel_data),
        .a_req   (inst_req),
        .a_wr    (inst_wr),
        .a_size  (inst_size),
        .a_addr  (inst_addr),
        .a_wdata (inst_wdata),
        .b_req   (data_req),
        .b_wr    (data_wr),
        .b_size  (data_size),
        .b_addr  (data_addr),
        .b_wdata (data_wdata),
        .y_req   (m_req),
        .y_wr    (m_wr),
        .y_size  (m_size),
        .y_addr  (m_addr),
        .y_wdata (m_wdata)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: state_next = pick(data_req, inst_req);
            ST_I_ADDR: begin
                // A dropped request abandons the grant rather than hanging the bus.
                if (!inst_req)
                    state_next = ST_IDLE;
                else if (m_addr_ok)
                    state_next = ST_I_DATA;
            end
            ST_D_ADDR: begin
                if (!data_req)
                    state_next = ST_IDLE;
                else if (m_addr_ok)
                    state_next = ST_D_DATA;
            end
            ST_I_DATA, ST_D_DATA: begin
                if (m_data_ok)
                    state_next = pick(data_req, inst_req);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign inst_addr_ok = (state_reg == ST_I_ADDR) && m_req && m_addr_ok;
    assign data_addr_ok = (state_reg == ST_D_ADDR) && m_req && m_addr_ok;
    assign inst_data_ok = (state_reg == ST_I_DATA) && m_data_ok;
    assign data_data_ok = (state_reg == ST_D_DATA) && m_data_ok;

    // Read data is shared; it is forced low only while reset is held.
    assign inst_rdata = rst ? m_rdata : '0;
    assign data_rdata = rst ? m_rdata : '0;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed scenarios plus randomized
// traffic against a grant/outstanding reference model.
module tb_sram_like_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]    inst_size = 2'd0;
    logic [AW-1:0] inst_addr = '0;
    logic [DW-1:0] inst_wdata = '0;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]    data_size = 2'd0;
    logic [AW-1:0] data_addr = '0;
    logic [DW-1:0] data_wdata = '0;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          m_req, m_wr;
    logic [1:0]    m_size;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_addr_ok = 1'b0, m_data_ok = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    sram_like_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: which port holds the bus (0 none, 1 inst, 2 data) and
    // whether its address has been accepted (response outstanding).
    int   owner    = 0;
    bit   accepted = 1'b0;
    bit   e_mreq, e_iaok, e_idok, e_daok, e_ddok;
    int   cnt_iaok = 0, cnt_idok = 0, cnt_daok = 0, cnt_ddok = 0, cnt_mreq = 0;

    function automatic int choose(input bit dreq, input bit ireq);
        return dreq ? 2 : (ireq ? 1 : 0);
    endfunction

    task automatic step();
        bit owner_req;
        @(negedge clk);
        owner_req = (owner == 1) ? inst_req : (owner == 2) ? data_req : 1'b0;
        e_mreq = rst && owner != 0 && !accepted && owner_req;
        e_iaok = e_mreq && owner == 1 && m_addr_ok;
        e_daok = e_mreq && owner == 2 && m_addr_ok;
        e_idok = rst && owner == 1 && accepted && m_data_ok;
        e_ddok = rst && owner == 2 && accepted && m_data_ok;
        chk("m_req", m_req, e_mreq);
        chk("inst_addr_ok", inst_addr_ok, e_iaok);
        chk("data_addr_ok", data_addr_ok, e_daok);
        chk("inst_data_ok", inst_data_ok, e_idok);
        chk("data_data_ok", data_data_ok, e_ddok);
        chk("inst_rdata", inst_rdata, rst ? m_rdata : '0);
        chk("data_rdata", data_rdata, rst ? m_rdata : '0);
        if (e_mreq) begin
            chk("m_wr",    m_wr,    owner == 2 ? data_wr    : inst_wr);
            chk("m_size",  m_size,  owner == 2 ? data_size  : inst_size);
            chk("m_addr",  m_addr,  owner == 2 ? data_addr  : inst_addr);
            chk("m_wdata", m_wdata, owner == 2 ? data_wdata : inst_wdata);
        end
        cnt_iaok += int'(inst_addr_ok);
        cnt_daok += int'(data_addr_ok);
        cnt_idok += int'(inst_data_ok);
        cnt_ddok += int'(data_data_ok);
        cnt_mreq += int'(m_req);
        if (inst_data_ok) $display("xact inst rdata=%08h t=%0t", inst_rdata, $time);
        if (data_data_ok) $display("xact data rdata=%08h t=%0t", data_rdata, $time);
        if (!rst) begin
            owner = 0; accepted = 1'b0;
        end else if (owner == 0) begin
            owner = choose(data_req, inst_req);
        end else if (!accepted) begin
            if (!owner_req) owner = 0;
            else if (m_addr_ok) accepted = 1'b1;
        end else if (m_data_ok) begin
            owner = choose(data_req, inst_req);
            accepted = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bus();
        inst_req = 0; data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 0;
    endtask

    int i0, d0, ia0, da0, mr0;

    initial begin
        // Reset state
        #2;
        chk("rst m_req", m_req, 1'b0);
        chk("rst data_addr_ok", data_addr_ok, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        step();

        // Reset asserted mid D_DATA
        data_req = 1; data_addr = 32'h8000_0040; data_size = 2'd2; m_addr_ok = 1;
        step(); step();
        data_req = 0; m_addr_ok = 0; m_rdata = 32'h1234_5678;
        #2 rst = 1'b0;
        #1;
        chk("async m_req", m_req, 1'b0);
        chk("async m_addr", m_addr, '0);
        chk("async data_rdata", data_rdata, '0);
        chk("async inst_rdata", inst_rdata, '0);
        chk("async data_data_ok", data_data_ok, 1'b0);
        owner = 0; accepted = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; m_data_ok = 1;
        d0 = cnt_ddok;
        step();
        chk("post-reset stray ddok", cnt_ddok - d0, 0);
        clear_bus(); step();

        // Inst read: addr_ok after 2 cycles, data_ok 3 cycles later
        i0 = cnt_idok; ia0 = cnt_iaok; d0 = cnt_ddok; da0 = cnt_daok;
        inst_req = 1; inst_addr = 32'hBFC0_0000; inst_size = 2'd2;
        step();
        chk("inst m_addr", m_addr, 64'hBFC0_0000);
        step();
        m_addr_ok = 1; step();
        m_addr_ok = 0; inst_req = 0;
        step(); step();
        m_data_ok = 1; m_rdata = 32'h3C1D_0000;
        #1 chk("inst rdata", inst_rdata, 64'h3C1D_0000);
        step();
        m_data_ok = 0; step();
        chk("inst aok pulses", cnt_iaok - ia0, 1);
        chk("inst dok pulses", cnt_idok - i0, 1);
        chk("data hs during inst", (cnt_daok - da0) + (cnt_ddok - d0), 0);

        // Contention: data write wins, inst follows without a bubble
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 1; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
        step();
        chk("cont m_wr", m_wr, 1'b1);
        chk("cont m_wdata", m_wdata, 64'hDEAD_BEEF);
        m_addr_ok = 1; step();
        data_req = 0; data_wr = 0; m_addr_ok = 0; m_data_ok = 1; step();
        m_data_ok = 0;
        chk("cont inst granted", m_req, 1'b1);
        chk("cont inst m_addr", m_addr, 64'hBFC0_0004);
        m_addr_ok = 1; step();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1; step();
        clear_bus(); step();

        // Back-to-back: four data reads with immediate bridge responses
        d0 = cnt_ddok; mr0 = cnt_mreq;
        m_addr_ok = 1; m_data_ok = 1;
        for (int k = 0; k < 4; k++) begin
            data_req = 1; data_addr = 32'(k * 4); data_size = 2'd2;
            m_rdata = 32'hA000_0000 + 32'(k);
            for (int b = 0; b < 10; b++) begin
                step();
                if (e_daok) break;
                if (b == 9) chk("b2b addr_ok timeout", 0, 1);
            end
            if (k == 3) data_req = 0;
        end
        step(); step();
        chk("b2b data_ok count", cnt_ddok - d0, 4);
        chk("b2b m_req count", cnt_mreq - mr0, 4);
        clear_bus(); step();

        // Abandoned inst request, then a normal data read
        ia0 = cnt_iaok; i0 = cnt_idok; d0 = cnt_ddok;
        inst_req = 1; inst_addr = 32'hBFC0_0100;
        step(); step();
        inst_req = 0; step(); step();
        chk("abandon inst hs", (cnt_iaok - ia0) + (cnt_idok - i0), 0);
        data_req = 1; data_addr = 32'h0000_0200; m_addr_ok = 1; step(); step();
        data_req = 0; m_addr_ok = 0; m_data_ok = 1; step();
        chk("after abandon ddok", cnt_ddok - d0, 1);
        clear_bus(); step();

        // Stray responses in IDLE and D_ADDR
        d0 = cnt_ddok; i0 = cnt_idok;
        m_data_ok = 1; step();
        data_req = 1; data_addr = 32'h0000_0300; step(); step();
        chk("stray still requesting", m_req, 1'b1);
        chk("stray no data_ok", (cnt_ddok - d0) + (cnt_idok - i0), 0);
        clear_bus(); step(); step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            m_addr_ok = ($urandom_range(0, 1) == 1);
            m_data_ok = ($urandom_range(0, 2) == 0);
            m_rdata   = $urandom;
            if (c == 300) begin
                rst = 1'b0;
            end else if (c == 302) begin
                rst = 1'b1;
            end
            step();
            if (e_iaok || (inst_req && $urandom_range(0, 49) == 0)) inst_req = 0;
            if (e_daok || (data_req && $urandom_range(0, 49) == 0)) data_req = 0;
            if (!inst_req && $urandom_range(0, 2) == 0) begin
                inst_req = 1; inst_addr = $urandom; inst_size = 2'($urandom_range(0, 2));
                inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(0, 3) == 0) begin
                data_req = 1; data_addr = $urandom; data_size = 2'($urandom_range(0, 2));
                data_wr = 1'($urandom); data_wdata = $urandom;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
